// File: rtl/relu_pkg.sv
// relu_pkg: shared definitions for the relu_stream block.
//   relu_state_e   - control FSM encoding (IDLE, RUN, DRAIN, DONE)
//   DEF_*          - default parameter values used by relu_stream and relu_lane
//   cnt_width()    - beat counter width for a given map size
// Optional feature macro: RELU_LEAKY_EN (adds the leak shift default).
package relu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } relu_state_e;

  localparam int DEF_DATA_WIDTH = 45;
  localparam int DEF_OUT_WIDTH  = 45;
  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_MAP_X      = 24;
  localparam int DEF_MAP_Y      = 24;
  localparam int DEF_OUT_SHIFT  = 0;
`ifdef RELU_LEAKY_EN
  localparam int DEF_LEAK_SHIFT = 3;
`endif

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// relu_lane: combinational activation for one channel lane.
//   x    (in)  signed DATA_WIDTH element
//   y    (out) signed OUT_WIDTH activated, shifted, saturated element
//   sat  (out) high when y was clipped to the output range
// Positive inputs are arithmetically shifted by OUT_SHIFT and clipped to the
// largest positive OUT_WIDTH value. Negative inputs become zero, or with
// RELU_LEAKY_EN defined are scaled down by LEAK_SHIFT, then OUT_SHIFT, and
// clipped to the most negative OUT_WIDTH value.
module relu_lane
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT
`ifdef RELU_LEAKY_EN
  ,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
`endif
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [OUT_WIDTH-1:0]  y,
  output logic                         sat
);

  // Output range limits expressed at the input width so the comparison is exact.
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
`ifdef RELU_LEAKY_EN
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    {{(DATA_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

  function automatic logic signed [DATA_WIDTH-1:0] act_shift(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if (v[DATA_WIDTH-1]) begin
`ifdef RELU_LEAKY_EN
      return (v >>> LEAK_SHIFT) >>> OUT_SHIFT;
`else
      return '0;
`endif
    end
    return v >>> OUT_SHIFT;
  endfunction

  function automatic logic sat_detect(input logic signed [DATA_WIDTH-1:0] v);
`ifdef RELU_LEAKY_EN
    return (v > SAT_MAX) || (v < SAT_MIN);
`else
    return (v > SAT_MAX);
`endif
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_clip(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
`ifdef RELU_LEAKY_EN
    if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
`endif
    return v[OUT_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = act_shift(x);
    sat     = sat_detect(shifted);
    y       = sat_clip(shifted);
  end

endmodule

// File: rtl/relu_stream.sv
// relu_stream: streaming ReLU over one MAP_X*MAP_Y-beat map of NUM_CH lanes.
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   relu_enable  start pulse, honoured only in IDLE
//   in_valid / in_ready / in_data    input beat handshake (lane k at k*DATA_WIDTH)
//   out_valid / out_ready / out_data output beat handshake (lane k at k*OUT_WIDTH)
//   out_last     marks the final beat of the map
//   relu_done    one-cycle pulse when the map has fully drained
//   busy         high whenever the FSM is not IDLE
//   sat_flag     sticky lane-saturation indicator, cleared on a new start
// Optional feature macro: RELU_LEAKY_EN (leaky negative slope, LEAK_SHIFT).
module relu_stream
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int MAP_X      = DEF_MAP_X,
  parameter int MAP_Y      = DEF_MAP_Y,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT
`ifdef RELU_LEAKY_EN
  ,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          relu_enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic                          relu_done,
  output logic                          busy,
  output logic                          sat_flag
);

  localparam int BEATS = MAP_X * MAP_Y;
  localparam int CNT_W = cnt_width(BEATS);

  relu_state_e                      state;
  logic        [CNT_W-1:0]          beat_cnt;
  logic        [NUM_CH*OUT_WIDTH-1:0] lane_y;
  logic        [NUM_CH-1:0]         lane_sat;
  logic        [NUM_CH*OUT_WIDTH-1:0] out_data_p1;
  logic                             vld_p1;
  logic                             last_p1;
  logic                             in_fire;
  logic                             out_fire;
  logic                             last_beat;

  // Stage p0: combinational activation of the presented input beat
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    relu_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .OUT_SHIFT  (OUT_SHIFT)
`ifdef RELU_LEAKY_EN
      ,
      .LEAK_SHIFT (LEAK_SHIFT)
`endif
    ) u_lane (
      .x   (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .y   (lane_y[k*OUT_WIDTH +: OUT_WIDTH]),
      .sat (lane_sat[k])
    );
  end

  // A held beat leaving this cycle frees the register for a new one, so the
  // input side stays open under continuous flow.
  assign in_ready  = (state == ST_RUN) && (!vld_p1 || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = vld_p1 && out_ready;
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      out_data_p1 <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (relu_enable) begin
            state    <= ST_RUN;
            beat_cnt <= '0;
            sat_flag <= 1'b0;
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            if (last_beat) state <= ST_DRAIN;
            else           beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_fire && last_p1) state <= ST_DONE;
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase

      // Stage p1: registered output beat, held until the consumer takes it
      if (in_fire) begin
        out_data_p1 <= lane_y;
        vld_p1      <= 1'b1;
        last_p1     <= last_beat;
        if (|lane_sat) sat_flag <= 1'b1;
      end else if (out_fire) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign relu_done = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_relu_stream.sv
// tb_relu_stream: randomized self-checking bench for relu_stream.
// Two instances: defaults (45-bit, 8 lanes, 24x24 map) and a narrow one
// (16-bit out, shift 4, 2 lanes, 2x2 map) for saturation.
module tb_relu_stream;

  localparam int DW      = 45;
  localparam int OW      = 45;
  localparam int NCH     = 8;
  localparam int BEATS   = 576;
  localparam int S_OW    = 16;
  localparam int S_SH    = 4;
  localparam int S_NCH   = 2;
  localparam int S_BEATS = 4;

`ifdef RELU_LEAKY_EN
  localparam logic [DW-1:0] EXP_M8 = 45'h1fff_ffff_ffff;
  localparam logic [DW-1:0] EXP_M1 = 45'h1fff_ffff_ffff;
`else
  localparam logic [DW-1:0] EXP_M8 = 45'h0;
  localparam logic [DW-1:0] EXP_M1 = 45'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en, iv, ir, ov, ordy, ol, done, busy, sat;
  logic [NCH*DW-1:0] idata;
  logic [NCH*OW-1:0] odata;
  logic s_en, s_iv, s_ir, s_ov, s_ordy, s_ol, s_done, s_busy, s_sat;
  logic [S_NCH*DW-1:0]   s_idata;
  logic [S_NCH*S_OW-1:0] s_odata;

  int n_tests = 0;
  int n_fail  = 0;

  relu_stream dut (
    .clk(clk), .rst(rst), .relu_enable(en),
    .in_valid(iv), .in_ready(ir), .in_data(idata),
    .out_valid(ov), .out_ready(ordy), .out_data(odata), .out_last(ol),
    .relu_done(done), .busy(busy), .sat_flag(sat)
  );

  relu_stream #(
    .DATA_WIDTH(DW), .OUT_WIDTH(S_OW), .NUM_CH(S_NCH),
    .MAP_X(2), .MAP_Y(2), .OUT_SHIFT(S_SH)
  ) dut_s (
    .clk(clk), .rst(rst), .relu_enable(s_en),
    .in_valid(s_iv), .in_ready(s_ir), .in_data(s_idata),
    .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_odata), .out_last(s_ol),
    .relu_done(s_done), .busy(s_busy), .sat_flag(s_sat)
  );

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: floor division by powers of two on plain integers.
  function automatic longint fdiv_pow2(input longint x, input int sh);
    longint d;
    longint q;
    d = 64'sd1 <<< sh;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint ref_act(input longint x, input int ow, input int osh, output bit s);
    longint maxv;
    longint minv;
    longint y;
    maxv = (64'sd1 <<< (ow - 1)) - 1;
    minv = -maxv - 1;
    if (x < 0) begin
`ifdef RELU_LEAKY_EN
      y = fdiv_pow2(fdiv_pow2(x, 3), osh);
`else
      y = 0;
`endif
    end else begin
      y = fdiv_pow2(x, osh);
    end
    s = 1'b0;
    if (y > maxv) begin y = maxv; s = 1'b1; end
    else if (y < minv) begin y = minv; s = 1'b1; end
    return y;
  endfunction

  function automatic logic [383:0] ref_bus(input logic [383:0] d, input int nch, input int ow,
                                           input int osh, output bit anysat);
    logic [383:0] r;
    logic signed [DW-1:0] sv;
    longint xs;
    longint y;
    bit s;
    r = '0;
    anysat = 1'b0;
    for (int k = 0; k < nch; k++) begin
      sv = d[k*DW +: DW];
      xs = sv;
      y = ref_act(xs, ow, osh, s);
      anysat = anysat | s;
      for (int b = 0; b < ow; b++) r[k*ow + b] = y[b];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    logic [63:0] t;
    case ($urandom_range(0, 9))
      0: t = 64'h0000_0fff_ffff_ffff;   // largest positive
      1: t = 64'h0000_1000_0000_0000;   // most negative
      2: t = 64'hffff_ffff_ffff_ffff;   // -1
      3: t = 64'h0;
      default: t = {$urandom, $urandom};
    endcase
    return t[DW-1:0];
  endfunction

  function automatic logic [NCH*DW-1:0] gen_beat(input int pat, input int idx);
    logic [NCH*DW-1:0] d;
    for (int k = 0; k < NCH; k++) begin
      if (pat == 0) d[k*DW +: DW] = (idx < 288) ? 45'h1fedcba98765 : 45'h0fedcba98765;
      else          d[k*DW +: DW] = rand_elem();
    end
    if (pat == 1 && idx == 0) begin
      d[0*DW +: DW] = 45'h1fff_ffff_fff8;  // -8
      d[1*DW +: DW] = 45'h1fff_ffff_ffff;  // -1
      d[2*DW +: DW] = 45'd7;
    end
    return d;
  endfunction

  task automatic run_map(input int pat, input int stall_at, input int abort_at, input bit poke);
    logic [383:0] eq_d[$];
    bit eq_l[$];
    int sent = 0, recv = 0, cyc = 0, stall_left = 0, last_xfer = -10;
    bit exp_sat = 1'b0, finished = 1'b0, aborted = 1'b0, stalled = 1'b0, bs;
    @(negedge clk);
    en = 1'b1; iv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    en = 1'b0;
    while (!finished && cyc < 20000) begin
      iv    = (sent < BEATS) && ((stall_left > 0) || ($urandom_range(0, 3) != 0));
      idata = gen_beat(pat, sent);
      ordy  = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 4) != 0);
      en    = poke && (sent == 50);
      #1;
      check("in_ready", ir, (sent < BEATS) && (!ov || ordy));
      check("busy", busy, 1);
      if (done) begin
        finished = 1'b1;
        check("done_after_last", last_xfer, cyc - 1);
        check("beats_out", recv, BEATS);
        check("sat_flag", sat, exp_sat);
      end
      if (ov) begin
        if (eq_d.size() == 0) begin
          check("spurious_valid", ov, 0);
        end else begin
          check("out_data", odata, eq_d[0]);
          check("out_last", ol, eq_l[0]);
          if (pat == 0 && recv == 0)   check("basic_first", odata[DW-1:0], 45'h0);
          if (pat == 0 && recv == 575) check("basic_last", odata[DW-1:0], 45'h0fedcba98765);
          if (pat == 1 && recv == 0) begin
            check("lane_m8", odata[0*OW +: OW], EXP_M8);
            check("lane_m1", odata[1*OW +: OW], EXP_M1);
            check("lane_p7", odata[2*OW +: OW], 45'd7);
          end
          if (ordy) begin
            void'(eq_d.pop_front());
            void'(eq_l.pop_front());
            recv++;
            last_xfer = cyc;
          end
        end
      end
      if (iv && ir) begin
        eq_d.push_back(ref_bus(384'(idata), NCH, OW, 0, bs));
        eq_l.push_back(sent == BEATS - 1);
        exp_sat = exp_sat | bs;
        sent++;
      end
      if (stall_left > 0) stall_left--;
      else if (!stalled && sent == stall_at) begin stall_left = 5; stalled = 1'b1; end
      if (abort_at >= 0 && sent > abort_at) begin aborted = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    en = 1'b0;
    if (aborted) begin
      @(negedge clk);
      iv = 1'b0; ordy = 1'b0; rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_out_valid", ov, 0);
      check("rst_out_last", ol, 0);
      check("rst_out_data", odata, 0);
      check("rst_done", done, 0);
      check("rst_sat", sat, 0);
      check("rst_in_ready", ir, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      @(negedge clk);
      iv = 1'b1; ordy = 1'b1;
      #1;
      check("no_restart_ready", ir, 0);
      check("no_restart_busy", busy, 0);
      iv = 1'b0;
    end else if (!finished) begin
      check("timeout", 0, 1);
    end else begin
      iv = 1'b0;
      #1;
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      check("queue_empty", eq_d.size(), 0);
    end
  endtask

  function automatic logic [S_NCH*DW-1:0] small_beat(input bit hot);
    logic [S_NCH*DW-1:0] d;
    longint r;
    for (int k = 0; k < S_NCH; k++) begin
      r = longint'($urandom_range(0, 524287)) - 262144;
      d[k*DW +: DW] = r[DW-1:0];
    end
    if (hot) d[DW-1:0] = 45'h0000_0010_0000;
    return d;
  endfunction

  task automatic run_small(input bit hot);
    logic [383:0] q[$];
    bit ql[$];
    int sent = 0, recv = 0, cyc = 0;
    bit exp_sat = 1'b0, fin = 1'b0, bs;
    @(negedge clk);
    s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    #1;
    check("s_sat_cleared", s_sat, 0);
    check("s_busy", s_busy, 1);
    while (!fin && cyc < 50) begin
      s_iv    = (sent < S_BEATS);
      s_ordy  = 1'b1;
      s_idata = small_beat(hot && sent == 0);
      #1;
      if (sent < S_BEATS) check("s_full_rate", s_ir, 1);
      if (s_done) begin
        fin = 1'b1;
        check("s_beats_out", recv, S_BEATS);
        check("s_sat_flag", s_sat, exp_sat);
      end
      if (s_ov) begin
        if (q.size() == 0) begin
          check("s_spurious_valid", s_ov, 0);
        end else begin
          check("s_out_data", s_odata, q[0]);
          check("s_out_last", s_ol, ql[0]);
          if (hot && recv == 0) check("s_sat_value", s_odata[S_OW-1:0], 16'h7fff);
          void'(q.pop_front());
          void'(ql.pop_front());
          recv++;
        end
      end
      if (s_iv && s_ir) begin
        q.push_back(ref_bus(384'(s_idata), S_NCH, S_OW, S_SH, bs));
        ql.push_back(sent == S_BEATS - 1);
        exp_sat = exp_sat | bs;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    s_iv = 1'b0;
    if (!fin) check("s_timeout", 0, 1);
    else if (hot) check("s_sat_sticky", s_sat, 1);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0; iv = 1'b0; ordy = 1'b0; idata = '0;
    s_en = 1'b0; s_iv = 1'b0; s_ordy = 1'b0; s_idata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("init_out_valid", ov, 0);
    check("init_out_data", odata, 0);
    check("init_in_ready", ir, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_sat", sat, 0);
    rst = 1'b1;

    run_map(0, 200, -1, 1'b0);   // basic map with a 5-cycle output stall
    run_map(1, 300, -1, 1'b1);   // random data, enable poked mid-run
    run_map(1, -1, 100, 1'b0);   // reset after beat 100
    run_map(1, -1, -1, 1'b0);    // full map after reset

    run_small(1'b0);
    run_small(1'b1);
    run_small(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_stream.md
RELU_STREAM -- requirements
Module: relu_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 45: signed input element width.
REQ-002 SHALL have parameter OUT_WIDTH, default 45: signed output element width, 2..DATA_WIDTH.
REQ-003 SHALL have parameter NUM_CH, default 8: parallel channel lanes per beat.
REQ-004 SHALL have parameter MAP_X, default 24, and MAP_Y, default 24: beats per map = MAP_X*MAP_Y.
REQ-005 SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift applied before width reduction.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port relu_enable, input, 1: start pulse for one map.
REQ-009 SHALL have port in_valid, input, 1, and in_ready, output, 1: input handshake.
REQ-010 SHALL have port in_data, input, NUM_CH*DATA_WIDTH: lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port out_valid, output, 1, and out_ready, input, 1: output handshake.
REQ-012 SHALL have port out_data, output, NUM_CH*OUT_WIDTH: lane k at bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-013 SHALL have port out_last, output, 1: high with the final beat of a map.
REQ-014 SHALL have port relu_done, output, 1: one-cycle pulse at map completion.
REQ-015 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-016 SHALL have port sat_flag, output, 1: sticky, set when any lane saturates; cleared on relu_enable accepted in IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> RUN (relu_enable in IDLE) -> DRAIN (last input beat accepted) -> DONE (last output beat transferred) -> IDLE (next cycle).
REQ-018 SHALL ignore relu_enable outside IDLE.
REQ-019 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-020 SHALL transfer a beat when valid && ready on the same edge; input beat result appears on out_data the cycle after acceptance (latency 1).
REQ-021 SHALL hold out_data, out_valid, out_last stable while out_valid && !out_ready.
REQ-022 SHALL count accepted beats 0..MAP_X*MAP_Y-1 and set out_last on the beat at count MAP_X*MAP_Y-1; counter wraps to 0 in DONE.
REQ-023 SHALL per lane compute: x<0 -> 0; else x >>> OUT_SHIFT, saturated to 2^(OUT_WIDTH-1)-1 if it exceeds that range.
REQ-024 SHALL pulse relu_done high for exactly the DONE cycle; busy low in that cycle's successor.
REQ-025 SHALL accept simultaneous output transfer and new input acceptance in one cycle without bubble (full throughput, one beat per clock).

Reset
REQ-026 SHALL on rst low at a rising edge: state IDLE, counter 0, out_valid 0, out_last 0, out_data 0, relu_done 0, sat_flag 0, in_ready 0.
REQ-027 SHALL on reset mid-map discard any held output beat and require a new relu_enable.

Configuration
REQ-028 SHALL with macro RELU_LEAKY_EN defined add parameter LEAK_SHIFT (default 3) and map x<0 to x >>> LEAK_SHIFT, then OUT_SHIFT, saturating to -2^(OUT_WIDTH-1) on underflow.
REQ-029 SHALL without RELU_LEAKY_EN map all negative inputs to 0 and contain no leak logic.

Structure
REQ-030 SHALL place FSM state enum and default width constants in shared package relu_pkg.
REQ-031 SHALL instantiate NUM_CH copies of combinational sub-module relu_lane (activation, shift, saturate, sat bit).

Verification
REQ-032 SHALL test basic map: defaults, lanes 45'h1fedcba98765 (negative) beats 0..287, 45'h0fedcba98765 beats 288..575 -> outputs 0 then 45'h0fedcba98765, out_last on beat 575, relu_done one pulse.
REQ-033 SHALL test backpressure: out_ready low 5 cycles mid-map -> in_ready low, out_data unchanged, no beat lost or duplicated.
REQ-034 SHALL test saturation: OUT_WIDTH=16, OUT_SHIFT=4, input 45'h0000_0010_0000 -> 16'h7fff, sat_flag 1; next relu_enable clears it.
REQ-035 SHALL test leaky (RELU_LEAKY_EN, LEAK_SHIFT=3): input -8 -> -1, input -1 -> -1, input 7 -> 7.
REQ-036 SHALL test reset after beat 100 -> all outputs at reset values next cycle; new relu_enable runs full 576-beat map.
REQ-037 SHALL test relu_enable asserted during RUN -> no effect on count or state.
